// File: rtl/bm_mult_accumulate_pkg.sv
// Shared constants and FSM state type for the multiplier product accumulator.
// Widths of the product stream derive from the operand width BITS.
package bm_mult_accumulate_pkg;

    localparam int unsigned BITS = 8;
    localparam int unsigned B2TS = 2 * BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/bm_acc_adder.sv
// Combinational accumulator adder: ACC_W add of a zero-extended product with carry-out.
// With SATURATE_EN defined the sum clamps to all-ones on carry-out; otherwise it wraps.
module bm_acc_adder
    import bm_mult_accumulate_pkg::*;
#(
    parameter int unsigned IN_W  = B2TS,
    parameter int unsigned ACC_W = 24
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [IN_W-1:0]  prod_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    logic [ACC_W:0] full;

    assign full    = {1'b0, acc_i} + {{(ACC_W + 1 - IN_W){1'b0}}, prod_i};
    assign carry_o = full[ACC_W];

`ifdef SATURATE_EN
    assign sum_o = carry_o ? '1 : full[ACC_W-1:0];
`else
    assign sum_o = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/bm_mult_accumulate.sv
// Block accumulator for the product stream: sums blk_len products, presents the sum on valid/ready.
// Overflow handling (wrap or clamp) selected by the SATURATE_EN macro inside bm_acc_adder.
module bm_mult_accumulate
    import bm_mult_accumulate_pkg::*;
#(
    parameter int unsigned IN_W  = B2TS,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] blk_len,
    input  logic [IN_W-1:0]  prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             ovf
);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;

    logic             in_xfer;
    logic             out_xfer;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic [ACC_W-1:0] prod_ext;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] cnt_inc;

    bm_acc_adder #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_adder (
        .acc_i   (acc_q),
        .prod_i  (prod_in),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    assign prod_ready = (state_q != HOLD);
    assign sum_valid  = (state_q == HOLD);
    assign sum_out    = sum_q;
    assign ovf        = ovf_q;

    assign in_xfer  = prod_valid & prod_ready;
    assign out_xfer = sum_valid & sum_ready;
    assign prod_ext = {{(ACC_W - IN_W){1'b0}}, prod_in};
    assign len_eff  = (blk_len == '0) ? CNT_W'(1) : blk_len;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    // First product loads directly; it cannot overflow since ACC_W > IN_W.
                    len_d = len_eff;
                    acc_d = prod_ext;
                    cnt_d = CNT_W'(1);
                    ovf_d = 1'b0;
                    if (len_eff == CNT_W'(1)) begin
                        state_d = HOLD;
                        sum_d   = prod_ext;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (in_xfer) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | add_carry;
                    if (cnt_inc == len_q) begin
                        state_d = HOLD;
                        sum_d   = add_sum;
                    end
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
